// File: rtl/banked_register_file.sv
// ARM-style 16-entry register file with FIQ/IRQ/SVC banking, CPSR/SPSR and N async read ports.
// Optional macro WRITE_BYPASS_EN forwards a same-cycle write to matching read ports.
module banked_register_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_READ_PORTS = 2,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] read_reg_num,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     read_data,
    input  logic                                     regwrite,
    input  logic [REG_ADDR_WIDTH-1:0]                write_reg,
    input  logic [DATA_WIDTH-1:0]                    write_data,
    input  logic                                     flag_write,
    input  logic                                     negative_flag,
    input  logic                                     zero_flag,
    input  logic                                     carry_flag,
    input  logic                                     overflow_flag,
    input  logic                                     mode_write,
    input  logic [1:0]                               new_mode,
    input  logic                                     exc_enter,
    input  logic [1:0]                               exc_mode,
    input  logic                                     spsr_restore,
    output logic [3:0]                               cpsr_flags,
    output logic [1:0]                               cpsr_mode,
    output logic [5:0]                               spsr_out
);

    localparam int NUM_PHYS = 27;
    localparam int PHYS_W   = 5;

    localparam logic [1:0] MODE_USR = 2'b00;
    localparam logic [1:0] MODE_FIQ = 2'b01;
    localparam logic [1:0] MODE_SVC = 2'b11;

    // Physical layout: 0-7 r0-r7, 8 r15, 9-13 USR r8-r12, 14-18 FIQ r8-r12,
    // 19-26 r13/r14 pairs for USR, FIQ, IRQ, SVC in mode-encoding order.
    function automatic logic [PHYS_W-1:0] phys_index(input logic [REG_ADDR_WIDTH-1:0] r,
                                                     input logic [1:0]                m);
        logic [PHYS_W-1:0] idx;
        if (!r[3])
            idx = {1'b0, r};
        else if (r == 4'd15)
            idx = 5'd8;
        else if (r <= 4'd12)
            idx = ((m == MODE_FIQ) ? 5'd14 : 5'd9) + {2'b00, r[2:0]};
        else
            idx = 5'd19 + {2'b00, m, 1'b0} + {4'b0000, r[1]};
        return idx;
    endfunction

    logic [DATA_WIDTH-1:0] regs [NUM_PHYS];
    logic [3:0]            flags_q, flags_d;
    logic [1:0]            mode_q, mode_d;
    logic [5:0]            spsr_q [4];
    logic                  spsr_we;
    logic [PHYS_W-1:0]     write_idx;

    assign write_idx = phys_index(write_reg, mode_q);

    // NOTE: the storage array is cleared on reset because every output must be defined from reset onward.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHYS; i++)
                regs[i] <= '0;
        end else if (regwrite) begin
            regs[write_idx] <= write_data;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        flags_d = flags_q;
        mode_d  = mode_q;
        spsr_we = 1'b0;
        if (exc_enter && exc_mode != MODE_USR) begin
            spsr_we = 1'b1;
            mode_d  = exc_mode;
        end else if (spsr_restore && mode_q != MODE_USR) begin
            {flags_d, mode_d} = spsr_q[mode_q];
        end else begin
            if (mode_write)
                mode_d = new_mode;
            if (flag_write)
                flags_d = {negative_flag, zero_flag, carry_flag, overflow_flag};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the SPSR captures the pre-edge CPSR.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= '0;
            mode_q  <= MODE_SVC;
            for (int i = 0; i < 4; i++)
                spsr_q[i] <= '0;
        end else begin
            flags_q <= flags_d;
            mode_q  <= mode_d;
            if (spsr_we)
                spsr_q[exc_mode] <= {flags_q, mode_q};
        end
    end

    always_comb begin
        read_data = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            read_data[p*DATA_WIDTH +: DATA_WIDTH] =
                regs[phys_index(read_reg_num[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH], mode_q)];
`ifdef WRITE_BYPASS_EN
            if (!reset && regwrite &&
                phys_index(read_reg_num[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH], mode_q) == write_idx)
                read_data[p*DATA_WIDTH +: DATA_WIDTH] = write_data;
`endif
        end
    end

    assign cpsr_flags = flags_q;
    assign cpsr_mode  = mode_q;
    assign spsr_out   = (mode_q == MODE_USR) ? 6'b000000 : spsr_q[mode_q];

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench: directed scenarios plus random traffic against a bank-level reference model.
module tb_banked_register_file;

    localparam int DW  = 32;
    localparam int NRP = 3;
    localparam int AW  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NRP*AW-1:0] read_reg_num;
    logic [NRP*DW-1:0] read_data;
    logic              regwrite;
    logic [AW-1:0]     write_reg;
    logic [DW-1:0]     write_data;
    logic              flag_write, negative_flag, zero_flag, carry_flag, overflow_flag;
    logic              mode_write;
    logic [1:0]        new_mode;
    logic              exc_enter;
    logic [1:0]        exc_mode;
    logic              spsr_restore;
    logic [3:0]        cpsr_flags;
    logic [1:0]        cpsr_mode;
    logic [5:0]        spsr_out;

    int checks = 0;
    int errors = 0;

    banked_register_file #(
        .DATA_WIDTH    (DW),
        .NUM_READ_PORTS(NRP),
        .REG_ADDR_WIDTH(AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .read_reg_num (read_reg_num),
        .read_data    (read_data),
        .regwrite     (regwrite),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .flag_write   (flag_write),
        .negative_flag(negative_flag),
        .zero_flag    (zero_flag),
        .carry_flag   (carry_flag),
        .overflow_flag(overflow_flag),
        .mode_write   (mode_write),
        .new_mode     (new_mode),
        .exc_enter    (exc_enter),
        .exc_mode     (exc_mode),
        .spsr_restore (spsr_restore),
        .cpsr_flags   (cpsr_flags),
        .cpsr_mode    (cpsr_mode),
        .spsr_out     (spsr_out)
    );

    always #5 clock = ~clock;

    // Reference model: one 16-entry view per mode; each architectural register lives in the view of the
    // mode that owns its copy (USR view for shared registers).
    logic [DW-1:0] m_regs [4][16];
    logic [3:0]    m_flags;
    logic [1:0]    m_mode;
    logic [5:0]    m_spsr [4];

    function automatic int bank_of(input int r, input logic [1:0] m);
        if (r < 8 || r == 15) return 0;
        if (r <= 12)          return (m == 2'b01) ? 1 : 0;
        return int'(m);
    endfunction

    function automatic logic [DW-1:0] m_read(input int r);
`ifdef WRITE_BYPASS_EN
        if (!reset && regwrite && r == int'(write_reg)) return write_data;
`endif
        return m_regs[bank_of(r, m_mode)][r];
    endfunction

    task automatic model_step();
        logic [5:0] pre;
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                for (int r = 0; r < 16; r++) m_regs[b][r] = '0;
                m_spsr[b] = '0;
            end
            m_flags = 4'b0000;
            m_mode  = 2'b11;
        end else begin
            pre = {m_flags, m_mode};
            if (regwrite) m_regs[bank_of(int'(write_reg), m_mode)][int'(write_reg)] = write_data;
            if (exc_enter && exc_mode != 2'b00) begin
                m_spsr[exc_mode] = pre;
                m_mode = exc_mode;
            end else if (spsr_restore && m_mode != 2'b00) begin
                {m_flags, m_mode} = m_spsr[m_mode];
            end else begin
                if (mode_write) m_mode = new_mode;
                if (flag_write) m_flags = {negative_flag, zero_flag, carry_flag, overflow_flag};
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NRP; p++)
            check($sformatf("%s rd%0d", tag, p), read_data[p*DW +: DW],
                  m_read(int'(read_reg_num[p*AW +: AW])));
        check({tag, " flags"}, 32'(cpsr_flags), 32'(m_flags));
        check({tag, " mode"}, 32'(cpsr_mode), 32'(m_mode));
        check({tag, " spsr"}, 32'(spsr_out), (m_mode == 2'b00) ? 32'd0 : 32'(m_spsr[m_mode]));
    endtask

    // Called just after a falling edge with inputs set; checks pre-edge outputs, then advances one cycle.
    task automatic tick(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clock);
        #1;
        model_step();
        @(negedge clock);
    endtask

    task automatic idle();
        regwrite = 0; write_reg = '0; write_data = '0;
        flag_write = 0; {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b0000;
        mode_write = 0; new_mode = 2'b00;
        exc_enter = 0; exc_mode = 2'b00; spsr_restore = 0;
    endtask

    task automatic set_ports(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        read_reg_num = {c, b, a};
    endtask

    task automatic do_write(input logic [3:0] r, input logic [31:0] d);
        idle(); regwrite = 1; write_reg = r; write_data = d;
        tick("wr");
    endtask

    logic [31:0] bypass_exp;

    initial begin
        reset = 1; idle();
        regwrite = 1; write_reg = 4'd2; write_data = 32'hFFFF_FFFF;
        set_ports(4'd2, 4'd0, 4'd15);
        @(posedge clock); #1; model_step(); @(negedge clock);
        tick("reset");
        reset = 0; idle();
        #1;
        check("rst r2", read_data[31:0], 32'd0);
        check("rst flags", 32'(cpsr_flags), 32'h0);
        check("rst mode", 32'(cpsr_mode), 32'h3);
        check("rst spsr", 32'(spsr_out), 32'h0);

        // Banking across SVC, USR and FIQ
        do_write(4'd13, 32'h1111_0000);
        idle(); mode_write = 1; new_mode = 2'b00; tick("to_usr");
        do_write(4'd13, 32'h2222_0000);
        do_write(4'd8, 32'h0000_0088);
        idle(); set_ports(4'd13, 4'd8, 4'd14); #1;
        check("usr r13", read_data[31:0], 32'h2222_0000);
        idle(); exc_enter = 1; exc_mode = 2'b01; tick("exc_fiq");
        #1;
        check("fiq r13", read_data[31:0], 32'h0);
        check("fiq r8", read_data[63:32], 32'h0);
        check("fiq spsr", 32'(spsr_out), 32'h00);
        idle(); spsr_restore = 1; tick("restore_fiq");
        #1;
        check("ret mode", 32'(cpsr_mode), 32'h0);
        check("ret r8", read_data[63:32], 32'h88);

        // Flags and SPSR
        idle(); flag_write = 1; negative_flag = 1; carry_flag = 1; tick("flagw");
        #1; check("flags nc", 32'(cpsr_flags), 32'ha);
        idle(); exc_enter = 1; exc_mode = 2'b10; tick("exc_irq");
        #1;
        check("irq mode", 32'(cpsr_mode), 32'h2);
        check("irq spsr", 32'(spsr_out), 32'h28);
        check("irq flags", 32'(cpsr_flags), 32'ha);
        idle(); spsr_restore = 1; tick("restore_irq");
        #1; check("irq ret mode", 32'(cpsr_mode), 32'h0);

        // Exception entry wins over a simultaneous flag write
        idle(); exc_enter = 1; exc_mode = 2'b11; flag_write = 1;
        {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b0101;
        tick("exc_svc_flag");
        idle(); set_ports(4'd13, 4'd8, 4'd0); #1;
        check("simul flags", 32'(cpsr_flags), 32'ha);
        check("simul spsr", 32'(spsr_out), 32'h28);
        check("svc r13", read_data[31:0], 32'h1111_0000);
        spsr_restore = 1; tick("restore_svc");

        // Ignored requests let lower priorities through
        idle(); exc_enter = 1; exc_mode = 2'b00; mode_write = 1; new_mode = 2'b10; tick("ign_exc");
        #1; check("ign exc mode", 32'(cpsr_mode), 32'h2);
        idle(); mode_write = 1; new_mode = 2'b00; tick("back_usr");
        idle(); spsr_restore = 1; flag_write = 1;
        {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b0011; tick("ign_ret");
        #1;
        check("ign ret flags", 32'(cpsr_flags), 32'h3);
        check("ign ret mode", 32'(cpsr_mode), 32'h0);

        // Multi-port reads
        do_write(4'd0, 32'hABCD_EF01);
        do_write(4'd1, 32'h0000_0005);
        do_write(4'd2, 32'h1234_5678);
        idle(); set_ports(4'd2, 4'd0, 4'd1); #1;
        check("mp port0", read_data[31:0], 32'h1234_5678);
        check("mp port1", read_data[63:32], 32'hABCD_EF01);
        check("mp port2", read_data[95:64], 32'h0000_0005);

        // Same-cycle write/read of r5
`ifdef WRITE_BYPASS_EN
        bypass_exp = 32'hABCD_EF01;
`else
        bypass_exp = 32'h0;
`endif
        idle(); set_ports(4'd5, 4'd5, 4'd6); regwrite = 1; write_reg = 4'd5; write_data = 32'hABCD_EF01;
        #1; check("byp pre", read_data[31:0], bypass_exp);
        tick("byp");
        idle(); #1; check("byp post", read_data[31:0], 32'hABCD_EF01);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            reset         = ($urandom_range(0, 63) == 0);
            regwrite      = $urandom_range(0, 1) == 1;
            write_reg     = 4'($urandom_range(0, 15));
            write_data    = $urandom;
            flag_write    = $urandom_range(0, 3) == 0;
            {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'($urandom_range(0, 15));
            mode_write    = $urandom_range(0, 7) == 0;
            new_mode      = 2'($urandom_range(0, 3));
            exc_enter     = $urandom_range(0, 7) == 0;
            exc_mode      = 2'($urandom_range(0, 3));
            spsr_restore  = $urandom_range(0, 7) == 0;
            read_reg_num  = 12'($urandom_range(0, 4095));
            tick("rnd");
        end
        reset = 0; idle();
        #1; check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banked_register_file.md
Name: banked_register_file

Overview:
- Parametrised successor to the flat `registers` block: a 16-entry ARM-style register file with mode-banked registers and multiple read ports.
- Holds CPSR (NZCV flags plus a 2-bit mode) and one SPSR per privileged mode.
- Supports exception entry (CPSR saved to SPSR) and SPSR restore.
- Sits between decode, ALU and the pipeline control/exception logic.

Parameters:
- DATA_WIDTH, 32, width of every general register.
- NUM_READ_PORTS, 2, number of independent asynchronous read ports (range 1..4).
- REG_ADDR_WIDTH, 4, architectural register index width; fixed at 16 architectural registers.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- read_reg_num  input  NUM_READ_PORTS*REG_ADDR_WIDTH  packed read indices, port p at bits [p*4+3:p*4]
- read_data  output  NUM_READ_PORTS*DATA_WIDTH  packed read data, same packing order
- regwrite  input  1  register write enable
- write_reg  input  REG_ADDR_WIDTH  write index
- write_data  input  DATA_WIDTH  write value
- flag_write  input  1  load CPSR flags from the four flag inputs
- negative_flag, zero_flag, carry_flag, overflow_flag  input  1 each  new NZCV values
- mode_write  input  1  load CPSR mode from new_mode
- new_mode  input  2  target mode
- exc_enter  input  1  exception entry request
- exc_mode  input  2  exception target mode
- spsr_restore  input  1  copy SPSR of the current mode into CPSR
- cpsr_flags  output  4  {N,Z,C,V}
- cpsr_mode  output  2  00 USR, 01 FIQ, 10 IRQ, 11 SVC
- spsr_out  output  6  {flags,mode} of the current mode's SPSR; 0 in USR

Behaviour:
- Reset:
  - Synchronous, active-high, takes priority over every other input in the same cycle.
  - All 27 physical registers and all SPSRs clear to 0.
  - cpsr_flags resets to 0000; cpsr_mode resets to SVC (11).
  - read_data reflects the cleared state; spsr_out is 0.
- Physical storage and banking:
  - r0-r7 and r15 are unbanked.
  - r8-r12 have a USR copy and an FIQ copy.
  - r13-r14 have separate USR, FIQ, IRQ and SVC copies.
  - IRQ and SVC share the USR copies of r8-r12.
  - r15 is an ordinary storage register here; there is no PC increment.
- Reads:
  - Combinational and zero latency.
  - Each port resolves its bank using the current cpsr_mode, i.e. the pre-edge value.
- Writes:
  - When regwrite=1, write_data is stored at the rising edge into the bank selected by the pre-edge cpsr_mode.
  - Read-back is visible one cycle later.
- CPSR next-state, in priority order:
  - 1) exc_enter with exc_mode!=USR: SPSR[exc_mode] <= pre-edge {flags,mode}; cpsr_mode <= exc_mode; flags unchanged.
  - 2) spsr_restore with cpsr_mode!=USR: {flags,mode} <= SPSR[cpsr_mode].
  - 3) mode_write: cpsr_mode <= new_mode.
  - 4) flag_write: cpsr_flags <= {negative_flag,zero_flag,carry_flag,overflow_flag}.
  - Item 4 applies only if neither 1 nor 2 fired.
  - Item 3 and item 4 may both apply in the same cycle.
- Ignored requests:
  - exc_enter with exc_mode=USR is ignored; a lower-priority request then proceeds.
  - spsr_restore in USR mode is ignored in the same way.
- Register writes are independent of CPSR events and always use the pre-edge mode.
- No X propagation: every output is defined from reset onward.

Optional Feature:
- Macro: WRITE_BYPASS_EN.
- When defined: if regwrite=1 and a read port resolves to the same physical register as the pending write, that port returns write_data combinationally in the same cycle.
- When undefined: reads always return stored contents, and the new value appears the cycle after the write.

Test Plan:
- Reset: hold reset 2 cycles with regwrite=1, write_reg=2, write_data=32'hFFFF_FFFF -> read r2=0, cpsr_flags=0000, cpsr_mode=11, spsr_out=0.
- Banking:
  - In SVC write r13=32'h1111_0000, then mode_write USR, then write r13=32'h2222_0000 and r8=32'h88.
  - Read r13 -> 2222_0000.
  - exc_enter FIQ -> r13=0, r8=0, spsr_out=6'b000000.
  - spsr_restore -> mode USR, r8=32'h88.
- Flags/SPSR: in USR, flag_write N=1 C=1 -> cpsr_flags=1010. Then exc_enter IRQ -> cpsr_mode=10, spsr_out=6'b101000, flags still 1010. Then spsr_restore -> cpsr_mode=00.
- Simultaneous events: exc_enter SVC plus flag_write 0101 in the same cycle, from flags 1010 in USR -> cpsr_flags stays 1010, spsr_out=6'b101000.
- Multi-port: NUM_READ_PORTS=3, write r0=32'hABCD_EF01, r1=32'h5, r2=32'h1234_5678; read ports 0,1,2 = r2,r0,r1 -> 1234_5678, ABCD_EF01, 0000_0005.
- Bypass: write r5=32'hABCD_EF01 while port0 reads r5, sampled before the edge -> ABCD_EF01 with WRITE_BYPASS_EN, 0 without; after the edge -> ABCD_EF01 in both builds.
